// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: intersection phase sequencer.
// Each served direction runs green -> yellow -> all-red. Directions with no
// vehicle demand are skipped, and an emergency request can preempt service.
// All outputs are registered, and every state update happens on the rising clock edge.
module traffic_light_ctrl #(
    parameter int unsigned GREEN_CYCLES  = 8,
    parameter int unsigned YELLOW_CYCLES = 3,
    parameter int unsigned ALLRED_CYCLES = 2,
    parameter int unsigned CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       emg_valid,
    input  logic [1:0] emg_dir,
    output logic [1:0] traffic_light,
    output logic       green,
    output logic       yellow
);

    typedef enum logic [1:0] {
        ST_ALL_RED,
        ST_GREEN,
        ST_YELLOW,
        ST_EMG_GREEN
    } state_t;

    // Counters are loaded with N-1 so that a phase lasts exactly N cycles.
    localparam logic [CNT_W-1:0] GREEN_LOAD  = CNT_W'(GREEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] YELLOW_LOAD = CNT_W'(YELLOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] ALLRED_LOAD = CNT_W'(ALLRED_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       traffic_light_q, traffic_light_d;
    logic             green_q, green_d;
    logic             yellow_q, yellow_d;

    // Round-robin pick: the first requesting direction after cur, wrapping back to cur.
    function automatic logic [1:0] pick_next(input logic [1:0] cur, input logic [3:0] r);
        logic [1:0] cand;
        logic [1:0] sel;
        logic       found;
        sel   = cur;
        found = 1'b0;
        cand  = cur;
        for (int k = 1; k <= 4; k++) begin
            cand = cur + 2'(k);
            if (!found && r[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    // Next-state, phase counter and registered-output decode.
    always_comb begin
        // NOTE: every signal gets a default before the case, so no path can leave one unassigned and infer a latch.
        state_d         = state_q;
        cnt_d           = cnt_q;
        traffic_light_d = traffic_light_q;

        unique case (state_q)
            ST_ALL_RED: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (emg_valid) begin
                    state_d         = ST_EMG_GREEN;
                    traffic_light_d = emg_dir;
                end else if (|req) begin
                    state_d         = ST_GREEN;
                    traffic_light_d = pick_next(traffic_light_q, req);
                    cnt_d           = GREEN_LOAD;
                end
                // With no demand, stay expired and re-evaluate on the next cycle.
            end
            ST_GREEN: begin
                if (emg_valid && (emg_dir == traffic_light_q)) begin
                    // Same direction: convert to emergency green with no gap.
                    state_d = ST_EMG_GREEN;
                end else if (emg_valid || (cnt_q == '0)) begin
                    // Truncate the green for a conflicting emergency, or end it at expiry.
                    state_d = ST_YELLOW;
                    cnt_d   = YELLOW_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_YELLOW: begin
                if (cnt_q == '0) begin
                    state_d = ST_ALL_RED;
                    cnt_d   = ALLRED_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_EMG_GREEN: begin
                // Held for as long as the request stays up; emg_dir is not re-sampled here.
                if (!emg_valid) begin
                    state_d = ST_YELLOW;
                    cnt_d   = YELLOW_LOAD;
                end
            end
            default: begin
                state_d = ST_ALL_RED;
                cnt_d   = ALLRED_LOAD;
            end
        endcase

        green_d  = (state_d == ST_GREEN) || (state_d == ST_EMG_GREEN);
        yellow_d = (state_d == ST_YELLOW);
    end

    // State register with synchronous reset into a full all-red clearance.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every flop samples its pre-edge value.
        if (rst) begin
            state_q         <= ST_ALL_RED;
            cnt_q           <= ALLRED_LOAD;
            traffic_light_q <= 2'd0;
            green_q         <= 1'b0;
            yellow_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            traffic_light_q <= traffic_light_d;
            green_q         <= green_d;
            yellow_q        <= yellow_d;
        end
    end

    assign traffic_light = traffic_light_q;
    assign green         = green_q;
    assign yellow        = yellow_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Self-checking bench for traffic_light_ctrl.
// A phase/age model is compared against the DUT on every cycle.
// Directed scenarios add hand-computed checkpoints at known cycles.
module tb_traffic_light_ctrl;

    localparam int G_N = 8;
    localparam int Y_N = 3;
    localparam int R_N = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       emg_valid;
    logic [1:0] emg_dir;
    logic [1:0] traffic_light;
    logic       green;
    logic       yellow;

    int n_checks = 0;
    int n_errors = 0;

    traffic_light_ctrl #(
        .GREEN_CYCLES (G_N),
        .YELLOW_CYCLES(Y_N),
        .ALLRED_CYCLES(R_N),
        .CNT_W        (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .emg_valid    (emg_valid),
        .emg_dir      (emg_dir),
        .traffic_light(traffic_light),
        .green        (green),
        .yellow       (yellow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: which phase we are in and how many cycles it has lasted so far.
    typedef enum {P_RED, P_GREEN, P_YELLOW, P_EMG} phase_t;
    phase_t m_phase;
    int     m_age;
    int     m_dir;
    bit     model_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase     = P_RED;
            m_age       = 1;
            m_dir       = 0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            case (m_phase)
                P_RED: begin
                    if (m_age >= R_N && emg_valid) begin
                        m_phase = P_EMG; m_dir = int'(emg_dir); m_age = 1;
                    end else if (m_age >= R_N && req != 4'b0000) begin
                        for (int k = 1; k <= 4; k++) begin
                            if (m_phase == P_RED && req[(m_dir + k) % 4]) begin
                                m_phase = P_GREEN;
                                m_dir   = (m_dir + k) % 4;
                            end
                        end
                        m_age = 1;
                    end else begin
                        m_age++;
                    end
                end
                P_GREEN: begin
                    if (emg_valid && int'(emg_dir) == m_dir) begin
                        m_phase = P_EMG; m_age = 1;
                    end else if (emg_valid || m_age == G_N) begin
                        m_phase = P_YELLOW; m_age = 1;
                    end else begin
                        m_age++;
                    end
                end
                P_YELLOW: begin
                    if (m_age == Y_N) begin
                        m_phase = P_RED; m_age = 1;
                    end else begin
                        m_age++;
                    end
                end
                P_EMG: begin
                    if (!emg_valid) begin
                        m_phase = P_YELLOW; m_age = 1;
                    end else begin
                        m_age++;
                    end
                end
                default: m_phase = P_RED;
            endcase
        end
    end

    // Every-cycle comparison, sampled on the falling edge.
    always @(negedge clk) begin
        if (model_valid) begin
            check("model_dir", int'(traffic_light), m_dir);
            check("model_green", int'(green), int'(m_phase == P_GREEN || m_phase == P_EMG));
            check("model_yellow", int'(yellow), int'(m_phase == P_YELLOW));
            check("green_and_yellow", int'(green & yellow), 0);
        end
    end

    // Each call returns 2 time units after the n-th rising edge.
    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        req       = 4'b0000;
        emg_valid = 1'b0;
        emg_dir   = 2'd0;

        // All four directions requesting: direction 1 is served first, then the others in rotation.
        req = 4'b1111;
        do_reset();
        cycles(1);  check("s1_allred_c2", int'(green), 0);
        cycles(1);  check("s1_first_green", int'(green), 1);
                    check("s1_first_dir", int'(traffic_light), 1);
        cycles(7);  check("s1_green_c8", int'(green), 1);
        cycles(1);  check("s1_yellow_c1", int'(yellow), 1);
                    check("s1_yellow_dir", int'(traffic_light), 1);
        cycles(5);  check("s1_dir2_green", int'(green), 1);
                    check("s1_dir2", int'(traffic_light), 2);
        cycles(39); check("s1_wrap_dir1", int'(traffic_light), 1);
                    check("s1_wrap_green", int'(green), 1);

        // No demand for 50 cycles, then a single request from direction 2.
        req = 4'b0000;
        do_reset();
        cycles(50); check("s2_idle_green", int'(green), 0);
                    check("s2_idle_yellow", int'(yellow), 0);
                    check("s2_idle_dir", int'(traffic_light), 0);
        req = 4'b0100;
        cycles(1);  check("s2_req_green", int'(green), 1);
                    check("s2_req_dir", int'(traffic_light), 2);

        // Only direction 3 requesting: it is served repeatedly.
        req = 4'b1000;
        cycles(40); check("s3_dir3", int'(traffic_light), 3);

        // Conflicting emergency on green cycle 3 of direction 0.
        req = 4'b0001;
        do_reset();
        cycles(2);  check("s4_green_dir0", int'(traffic_light), 0);
                    check("s4_green", int'(green), 1);
        cycles(2);
        emg_valid = 1'b1;
        emg_dir   = 2'd2;
        cycles(1);  check("s4_trunc_yellow", int'(yellow), 1);
                    check("s4_trunc_dir", int'(traffic_light), 0);
        cycles(5);  check("s4_emg_green", int'(green), 1);
                    check("s4_emg_dir", int'(traffic_light), 2);
        cycles(20); check("s4_emg_held", int'(green), 1);
        emg_valid = 1'b0;
        cycles(1);  check("s4_release_yellow", int'(yellow), 1);
                    check("s4_release_dir", int'(traffic_light), 2);
        cycles(3);  check("s4_allred", int'(green | yellow), 0);

        // Emergency on the direction that already has green.
        req = 4'b0010;
        do_reset();
        cycles(2);  check("s5_green_dir1", int'(traffic_light), 1);
        emg_valid = 1'b1;
        emg_dir   = 2'd1;
        cycles(5);
        emg_dir   = 2'd3;
        cycles(10); check("s5_held_green", int'(green), 1);
                    check("s5_held_noyellow", int'(yellow), 0);
                    check("s5_held_dir", int'(traffic_light), 1);
        req       = 4'b1111;
        emg_valid = 1'b0;
        cycles(1);  check("s5_release_yellow", int'(yellow), 1);
        cycles(5);  check("s5_next_green", int'(green), 1);
                    check("s5_next_dir", int'(traffic_light), 2);

        // Reset asserted during yellow cycle 2.
        req = 4'b1111;
        do_reset();
        cycles(11); check("s6_yellow_c2", int'(yellow), 1);
        rst = 1'b1;
        cycles(1);  check("s6_rst_green", int'(green), 0);
                    check("s6_rst_yellow", int'(yellow), 0);
                    check("s6_rst_dir", int'(traffic_light), 0);
        rst = 1'b0;
        cycles(2);  check("s6_restart_green", int'(green), 1);
                    check("s6_restart_dir", int'(traffic_light), 1);
        cycles(20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
